tlm_get_responder: RTL

TLM_GET_RESPONDER -- requirements
Module: tlm_get_responder

---
 rtl/tlm_get_responder_if.sv | 45 ++++
 rtl/tlm_get_responder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tlm_get_responder_if.sv
// Handshake bundle for tlm_get_responder: put channel, blocking/non-blocking get, status.
// Peek signals exist only when TLM_GET_RESPONDER_PEEK_EN is defined.
interface tlm_get_responder_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              put_valid;
  logic [DATA_W-1:0] put_data;
  logic              put_ready;
  logic              get_req;
  logic              get_ack;
  logic              try_get;
  logic              try_done;
  logic              try_ok;
  logic [DATA_W-1:0] get_data;
  logic              can_get;
  logic [CW-1:0]     count;
`ifdef TLM_GET_RESPONDER_PEEK_EN
  logic              peek_req;
  logic              peek_done;
  logic              peek_ok;

  modport master (
    output put_valid, put_data, get_req, try_get, peek_req,
    input  put_ready, get_ack, try_done, try_ok, get_data, can_get, count,
           peek_done, peek_ok
  );
  modport slave (
    input  put_valid, put_data, get_req, try_get, peek_req,
    output put_ready, get_ack, try_done, try_ok, get_data, can_get, count,
           peek_done, peek_ok
  );
`else
  modport master (
    output put_valid, put_data, get_req, try_get,
    input  put_ready, get_ack, try_done, try_ok, get_data, can_get, count
  );
  modport slave (
    input  put_valid, put_data, get_req, try_get,
    output put_ready, get_ack, try_done, try_ok, get_data, can_get, count
  );
`endif
endinterface

// File: rtl/tlm_get_responder.sv
// In-order FIFO answering blocking gets (IDLE/WAIT/ACK FSM) and single-cycle try_gets.
// Optional non-destructive peek: define TLM_GET_RESPONDER_PEEK_EN.
module tlm_get_responder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tlm_get_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // Async assert, release synchronised to clk.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] get_data_q;
  logic              try_done_q, try_ok_q;
  logic              nonempty, push, pop;
  logic              try_done_nx, try_ok_nx;
  state_t            state, state_nx;

  assign nonempty = (cnt != '0);
  assign push     = bus.put_valid && (cnt != CW'(DEPTH));

`ifdef TLM_GET_RESPONDER_PEEK_EN
  logic peek_done_q, peek_ok_q, peek_ok_nx, peek_rd;
`endif

  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    try_done_nx = bus.try_get;
    try_ok_nx   = 1'b0;
`ifdef TLM_GET_RESPONDER_PEEK_EN
    peek_ok_nx  = 1'b0;
    peek_rd     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.get_req) begin
          if (nonempty) begin
            pop      = 1'b1;
            state_nx = ACK;
          end else begin
            state_nx = WAIT;
          end
        end else if (bus.try_get) begin
          try_ok_nx = nonempty;
          pop       = nonempty;
        end
`ifdef TLM_GET_RESPONDER_PEEK_EN
        else if (bus.peek_req) begin
          peek_ok_nx = nonempty;
          peek_rd    = nonempty;
        end
`endif
      end
      // A committed get ignores get_req until it completes.
      WAIT: begin
        if (nonempty) begin
          pop      = 1'b1;
          state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.put_data;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      get_data_q <= '0;
      try_done_q <= 1'b0;
      try_ok_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt        <= cnt + CW'(push) - CW'(pop);
      try_done_q <= try_done_nx;
      try_ok_q   <= try_ok_nx;
`ifdef TLM_GET_RESPONDER_PEEK_EN
      if (pop || peek_rd) get_data_q <= mem[rd_ptr];
`else
      if (pop) get_data_q <= mem[rd_ptr];
`endif
    end
  end

`ifdef TLM_GET_RESPONDER_PEEK_EN
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      peek_done_q <= 1'b0;
      peek_ok_q   <= 1'b0;
    end else begin
      peek_done_q <= bus.peek_req;
      peek_ok_q   <= peek_ok_nx;
    end
  end
  assign bus.peek_done = peek_done_q;
  assign bus.peek_ok   = peek_ok_q;
`endif

  assign bus.put_ready = (cnt != CW'(DEPTH));
  assign bus.get_ack   = (state == ACK);
  assign bus.try_done  = try_done_q;
  assign bus.try_ok    = try_ok_q;
  assign bus.get_data  = get_data_q;
  assign bus.can_get   = nonempty;
  assign bus.count     = cnt;

endmodule
